// File: rtl/tluh_pkg.sv
// Shared widths, opcodes, params and state encoding for the TL-UH atomic sequencer.
package tluh_pkg;

  localparam int unsigned TL_AW  = 32;
  localparam int unsigned TL_DW  = 32;
  localparam int unsigned TL_DBW = TL_DW / 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    CALC,
    WR_REQ,
    RESP
  } atomic_state_e;

  localparam logic [2:0] ArithmeticData = 3'd2;
  localparam logic [2:0] LogicalData    = 3'd3;

  localparam logic [2:0] ARITH_MIN  = 3'd0;
  localparam logic [2:0] ARITH_MAX  = 3'd1;
  localparam logic [2:0] ARITH_MINU = 3'd2;
  localparam logic [2:0] ARITH_MAXU = 3'd3;
  localparam logic [2:0] ARITH_ADD  = 3'd4;

  localparam logic [2:0] LOGIC_XOR  = 3'd0;
  localparam logic [2:0] LOGIC_OR   = 3'd1;
  localparam logic [2:0] LOGIC_AND  = 3'd2;
  localparam logic [2:0] LOGIC_SWAP = 3'd3;

  // Captured atomic request; the opcode is kept only as its arithmetic/logical decode.
  typedef struct packed {
    logic              arith;
    logic [2:0]        param;
    logic [TL_AW-1:0]  addr;
    logic [TL_DW-1:0]  data;
    logic [TL_DBW-1:0] mask;
  } atomic_req_t;

  function automatic logic atomic_legal(input logic [2:0] opcode, input logic [2:0] param);
    case (opcode)
      ArithmeticData: return (param <= ARITH_ADD);
      LogicalData:    return (param <= LOGIC_SWAP);
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/tluh_byte_merge.sv
// Byte-lane merge: masked lanes take the new value, unmasked lanes keep the old one.
module tluh_byte_merge #(
  parameter int unsigned TL_DBW = 4
) (
  input  logic [TL_DBW*8-1:0] old_data,
  input  logic [TL_DBW*8-1:0] new_data,
  input  logic [TL_DBW-1:0]   mask,
  output logic [TL_DBW*8-1:0] merged_c
);

  always_comb begin
    merged_c = old_data;
    for (int unsigned i = 0; i < TL_DBW; i++) begin
      if (mask[i]) merged_c[i*8 +: 8] = new_data[i*8 +: 8];
    end
  end

endmodule

// File: rtl/tluh_atomic_seq.sv
// Read-modify-write sequencer for TL-UH Arithmetic/Logical atomics; returns the pre-op value.
module tluh_atomic_seq
  import tluh_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        req_opcode_i,
  input  logic [2:0]        req_param_i,
  input  logic [TL_AW-1:0]  req_addr_i,
  input  logic [TL_DW-1:0]  req_data_i,
  input  logic [TL_DBW-1:0] req_mask_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [TL_AW-1:0]  mem_addr_o,
  output logic [TL_DW-1:0]  mem_wdata_o,
  output logic [TL_DBW-1:0] mem_be_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [TL_DW-1:0]  mem_rdata_i,
  input  logic              mem_err_i,
  output logic              alu_enable_o,
  output logic [TL_DW-1:0]  alu_op1_o,
  output logic [TL_DW-1:0]  alu_op2_o,
  output logic              alu_cin_o,
  output logic              alu_operation_o,
  output logic [2:0]        alu_function_o,
  input  logic [TL_DW-1:0]  alu_result_i,
  input  logic              alu_cout_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [TL_DW-1:0]  rsp_data_o,
  output logic              rsp_error_o
);

  atomic_state_e    state_q, state_d;
  atomic_req_t      req_q;
  logic [TL_DW-1:0] old_q;
  logic [TL_DW-1:0] merged_q;
  logic [TL_DW-1:0] merged_c;
  logic             err_q;
  logic             req_legal_c;
  logic             req_ready_d, mem_req_d, mem_we_d, alu_enable_d, rsp_valid_d;
  logic             unused_cout;

  assign unused_cout = alu_cout_i;
  assign req_legal_c = atomic_legal(req_opcode_i, req_param_i);

  // Next state plus the registered-output values for that state.
  always_comb begin : fsm_next
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid_i)  state_d = req_legal_c ? RD_REQ : RESP;
      RD_REQ:  if (mem_gnt_i)    state_d = RD_WAIT;
      RD_WAIT: if (mem_rvalid_i) state_d = mem_err_i ? RESP : CALC;
      CALC:                      state_d = WR_REQ;
      WR_REQ:  if (mem_gnt_i)    state_d = RESP;
      RESP:    if (rsp_ready_i)  state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
    req_ready_d  = (state_d == IDLE);
    mem_req_d    = (state_d == RD_REQ) || (state_d == WR_REQ);
    mem_we_d     = (state_d == WR_REQ);
    alu_enable_d = (state_d == CALC);
    rsp_valid_d  = (state_d == RESP);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin : fsm_reg
    if (rst_i) begin
      state_q      <= IDLE;
      req_ready_o  <= 1'b1;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      alu_enable_o <= 1'b0;
      rsp_valid_o  <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_o  <= req_ready_d;
      mem_req_o    <= mem_req_d;
      mem_we_o     <= mem_we_d;
      alu_enable_o <= alu_enable_d;
      rsp_valid_o  <= rsp_valid_d;
    end
  end

  // Request capture, old-value capture and merged-result capture.
  always_ff @(posedge clk_i or posedge rst_i) begin : datapath
    if (rst_i) begin
      req_q    <= '0;
      old_q    <= '0;
      merged_q <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (req_valid_i) begin
          req_q    <= '{arith: (req_opcode_i == ArithmeticData), param: req_param_i,
                        addr: req_addr_i, data: req_data_i, mask: req_mask_i};
          old_q    <= '0;
          merged_q <= '0;
          err_q    <= ~req_legal_c;
        end
        RD_WAIT: if (mem_rvalid_i) begin
          old_q <= mem_rdata_i;
          err_q <= mem_err_i;
        end
        CALC:    merged_q <= merged_c;
        default: ;
      endcase
    end
  end

  tluh_byte_merge #(.TL_DBW(TL_DBW)) u_merge (
    .old_data (old_q),
    .new_data (alu_result_i),
    .mask     (req_q.mask),
    .merged_c (merged_c)
  );

  assign mem_addr_o      = req_q.addr;
  assign mem_be_o        = req_q.mask;
  assign mem_wdata_o     = merged_q;
  assign alu_op1_o       = old_q;
  assign alu_op2_o       = req_q.data;
  assign alu_cin_o       = 1'b0;
  assign alu_operation_o = req_q.arith;
  assign alu_function_o  = req_q.param;
  assign rsp_data_o      = old_q;
  assign rsp_error_o     = err_q;

endmodule

// File: tb/tb_tluh_atomic_seq.sv
// Scoreboarded bench for tluh_atomic_seq with a delay-configurable memory and a reference ALU.
module tb_tluh_atomic_seq;
  import tluh_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [2:0]  req_opcode_i = '0;
  logic [2:0]  req_param_i = '0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_data_i = '0;
  logic [3:0]  req_mask_i = '0;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_err_i = 1'b0;
  logic        alu_enable_o, alu_cin_o, alu_operation_o;
  logic [31:0] alu_op1_o, alu_op2_o, alu_result_i;
  logic [2:0]  alu_function_o;
  logic        alu_cout_i = 1'b0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_data_o;
  logic        rsp_error_o;

  int checks = 0;
  int errors = 0;

  // Memory model knobs and state
  int          gnt_delay = 0;
  int          rv_delay = 0;
  logic        rv_err = 1'b0;
  int          gnt_cnt = 0;
  int          rv_cnt = 0;
  bit          rv_pend = 1'b0;
  logic [31:0] rv_addr = '0;
  int          req_cycles = 0;
  logic [31:0] mem [logic [31:0]];

  typedef struct packed {logic [31:0] addr; logic [31:0] data; logic [3:0] be;} wr_t;
  typedef struct packed {logic [31:0] data; logic err;} rsp_t;
  wr_t  wr_obs[$];
  wr_t  exp_wr[$];
  rsp_t exp_rsp[$];

  tluh_atomic_seq dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_opcode_i(req_opcode_i),
    .req_param_i(req_param_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_mask_i(req_mask_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .alu_enable_o(alu_enable_o), .alu_op1_o(alu_op1_o), .alu_op2_o(alu_op2_o),
    .alu_cin_o(alu_cin_o), .alu_operation_o(alu_operation_o), .alu_function_o(alu_function_o),
    .alu_result_i(alu_result_i), .alu_cout_i(alu_cout_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_error_o(rsp_error_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] alu_ref(input logic arith, input logic [2:0] fn,
                                          input logic [31:0] a, input logic [31:0] b);
    if (arith) begin
      case (fn)
        ARITH_MIN:  return ($signed(a) < $signed(b)) ? a : b;
        ARITH_MAX:  return ($signed(a) > $signed(b)) ? a : b;
        ARITH_MINU: return (a < b) ? a : b;
        ARITH_MAXU: return (a > b) ? a : b;
        default:    return a + b;
      endcase
    end
    case (fn)
      LOGIC_XOR: return a ^ b;
      LOGIC_OR:  return a | b;
      LOGIC_AND: return a & b;
      default:   return b;
    endcase
  endfunction

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] be_write(input logic [31:0] old, input logic [31:0] nw,
                                           input logic [3:0] be);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  // Stand-in for the parent's ALU
  always_comb alu_result_i = alu_ref(alu_operation_o, alu_function_o, alu_op1_o, alu_op2_o);

  // Memory responder; logs granted writes
  always @(negedge clk_i) begin
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_err_i    = 1'b0;
    mem_rdata_i  = 32'hDEAD_BEEF;
    if (rv_pend) begin
      if (rv_cnt == 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rd_mem(rv_addr);
        mem_err_i    = rv_err;
        rv_pend      = 1'b0;
      end else rv_cnt--;
    end
    if (mem_req_o === 1'b1) begin
      req_cycles++;
      if (gnt_cnt >= gnt_delay) begin
        mem_gnt_i = 1'b1;
        gnt_cnt   = 0;
        if (mem_we_o) begin
          wr_obs.push_back('{mem_addr_o, mem_wdata_o, mem_be_o});
          mem[mem_addr_o] = be_write(rd_mem(mem_addr_o), mem_wdata_o, mem_be_o);
        end else begin
          rv_pend = 1'b1;
          rv_cnt  = rv_delay;
          rv_addr = mem_addr_o;
        end
      end else gnt_cnt++;
    end
  end

  // Accepts at the negedge where ready is seen; returns at the negedge of cycle 1.
  task automatic send_req(input logic [2:0] op, input logic [2:0] prm, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] m);
    int n = 0;
    while (req_ready_o !== 1'b1 && n < 100) begin @(negedge clk_i); n++; end
    req_valid_i = 1'b1; req_opcode_i = op; req_param_i = prm;
    req_addr_i = a; req_data_i = d; req_mask_i = m;
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 1;
    while (rsp_valid_o !== 1'b1 && cyc < 300) begin @(negedge clk_i); cyc++; end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b, expected 1", req_ready_o);
    end
    checks++;
    if ({mem_req_o, mem_we_o, alu_enable_o, alu_operation_o, alu_function_o, alu_cin_o,
         rsp_valid_o, rsp_error_o} !== 10'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b, expected 0",
        {mem_req_o, mem_we_o, alu_enable_o, alu_operation_o, alu_function_o, alu_cin_o,
         rsp_valid_o, rsp_error_o});
    end
    checks++;
    if ({mem_addr_o, mem_wdata_o, mem_be_o, alu_op1_o, alu_op2_o, rsp_data_o} !== '0) begin
      errors++; $display("FAIL reset_data: addr %h wdata %h op1 %h rsp %h, expected 0",
        mem_addr_o, mem_wdata_o, alu_op1_o, rsp_data_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_add();
    int cyc, r0;
    rsp_t e; wr_t w;
    mem[32'h40] = 32'h0000_0010;
    exp_rsp.push_back('{32'h0000_0010, 1'b0});
    exp_wr.push_back('{32'h40, 32'h0000_0015, 4'hF});
    r0 = req_cycles;
    send_req(ArithmeticData, ARITH_ADD, 32'h40, 32'h5, 4'hF);
    wait_rsp(cyc);
    e = exp_rsp.pop_front();
    checks++;
    if (cyc != 5) begin errors++; $display("FAIL add_latency: got cycle %0d, expected 5", cyc); end
    checks++;
    if ({rsp_data_o, rsp_error_o} !== {e.data, e.err}) begin
      errors++; $display("FAIL add_rsp: got %h/%b, expected %h/%b", rsp_data_o, rsp_error_o, e.data, e.err);
    end
    @(negedge clk_i);
    checks++;
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL add_ready_c6: got %b, expected 1", req_ready_o); end
    w = exp_wr.pop_front();
    checks++;
    if (wr_obs.size() != 1) begin
      errors++; $display("FAIL add_wr_count: got %0d, expected 1", wr_obs.size());
    end else if (wr_obs.pop_front() !== w) begin
      errors++; $display("FAIL add_wr: expected addr %h data %h be %h", w.addr, w.data, w.be);
    end
    checks++;
    if (req_cycles - r0 != 2) begin
      errors++; $display("FAIL add_req_cycles: got %0d, expected 2", req_cycles - r0);
    end
    wr_obs.delete();
  endtask

  task automatic test_and_partial();
    int cyc;
    rsp_t e; wr_t w, o;
    mem[32'h44] = 32'hFFFF_FFFF;
    exp_rsp.push_back('{32'hFFFF_FFFF, 1'b0});
    exp_wr.push_back('{32'h44, 32'hFFFF_0000, 4'h3});
    send_req(LogicalData, LOGIC_AND, 32'h44, 32'h0, 4'h3);
    wait_rsp(cyc);
    e = exp_rsp.pop_front();
    checks++;
    if (cyc != 5 || {rsp_data_o, rsp_error_o} !== {e.data, e.err}) begin
      errors++; $display("FAIL and_rsp: got cyc %0d %h/%b, expected cyc 5 %h/%b",
        cyc, rsp_data_o, rsp_error_o, e.data, e.err);
    end
    @(negedge clk_i);
    w = exp_wr.pop_front();
    o = (wr_obs.size() == 1) ? wr_obs.pop_front() : '0;
    checks++;
    if (o !== w) begin
      errors++; $display("FAIL and_wr: got %h %h %h, expected %h %h %h", o.addr, o.data, o.be, w.addr, w.data, w.be);
    end
    wr_obs.delete();
  endtask

  task automatic test_illegal();
    logic [2:0] ops[3] = '{ArithmeticData, LogicalData, 3'd4};
    logic [2:0] prm[3] = '{3'd5, 3'd4, 3'd0};
    int cyc, r0;
    rsp_t e;
    for (int i = 0; i < 3; i++) begin
      exp_rsp.push_back('{32'h0, 1'b1});
      r0 = req_cycles;
      send_req(ops[i], prm[i], 32'h40, 32'h1234_5678, 4'hF);
      wait_rsp(cyc);
      e = exp_rsp.pop_front();
      checks++;
      if (cyc != 1 || {rsp_data_o, rsp_error_o} !== {e.data, e.err}) begin
        errors++; $display("FAIL illegal_rsp[%0d]: got cyc %0d %h/%b, expected cyc 1 %h/%b",
          i, cyc, rsp_data_o, rsp_error_o, e.data, e.err);
      end
      @(negedge clk_i);
      checks++;
      if (req_cycles != r0 || wr_obs.size() != 0) begin
        errors++; $display("FAIL illegal_mem[%0d]: got %0d req cycles %0d writes, expected 0",
          i, req_cycles - r0, wr_obs.size());
      end
    end
  endtask

  task automatic test_read_error();
    int cyc;
    rsp_t e;
    mem[32'h48] = 32'hA5A5_A5A5;
    rv_err = 1'b1;
    exp_rsp.push_back('{32'hA5A5_A5A5, 1'b1});
    send_req(ArithmeticData, ARITH_ADD, 32'h48, 32'h1, 4'hF);
    wait_rsp(cyc);
    rv_err = 1'b0;
    e = exp_rsp.pop_front();
    checks++;
    if (cyc != 3 || {rsp_data_o, rsp_error_o} !== {e.data, e.err}) begin
      errors++; $display("FAIL rderr_rsp: got cyc %0d %h/%b, expected cyc 3 %h/%b",
        cyc, rsp_data_o, rsp_error_o, e.data, e.err);
    end
    repeat (3) @(negedge clk_i);
    checks++;
    if (wr_obs.size() != 0 || mem_req_o !== 1'b0) begin
      errors++; $display("FAIL rderr_nowrite: got %0d writes req %b, expected 0", wr_obs.size(), mem_req_o);
    end
  endtask

  task automatic test_stalls();
    int cyc, held, first;
    bit in_req;
    logic [67:0] snap;
    rsp_t e; wr_t w, o;
    mem[32'h80] = 32'h0000_00F0;
    exp_rsp.push_back('{32'h0000_00F0, 1'b0});
    exp_wr.push_back('{32'h80, 32'h0000_0101, 4'hF});
    gnt_delay = 3; rv_delay = 2; rsp_ready_i = 1'b0;
    send_req(ArithmeticData, ARITH_ADD, 32'h80, 32'h11, 4'hF);
    e = exp_rsp.pop_front();
    cyc = 1; held = 0; first = 0; in_req = 1'b0; snap = '0;
    while (cyc < 300) begin
      if (mem_req_o === 1'b1) begin
        if (!in_req) begin in_req = 1'b1; snap = {mem_addr_o, mem_wdata_o, mem_be_o}; end
        else begin
          checks++;
          if ({mem_addr_o, mem_wdata_o, mem_be_o} !== snap) begin
            errors++; $display("FAIL stall_stable: cycle %0d got %h, expected %h", cyc,
              {mem_addr_o, mem_wdata_o, mem_be_o}, snap);
          end
        end
      end else in_req = 1'b0;
      checks++;
      if (req_ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready: cycle %0d got %b, expected 0", cyc, req_ready_o); end
      if (rsp_valid_o === 1'b1) begin
        if (first == 0) first = cyc;
        held++;
        checks++;
        if ({rsp_data_o, rsp_error_o} !== {e.data, e.err}) begin
          errors++; $display("FAIL stall_rsp: cycle %0d got %h/%b, expected %h/%b", cyc, rsp_data_o, rsp_error_o, e.data, e.err);
        end
      end
      if (held == 4) break;
      @(negedge clk_i); cyc++;
    end
    checks++;
    if (first != 13) begin errors++; $display("FAIL stall_latency: got cycle %0d, expected 13", first); end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      errors++; $display("FAIL stall_handshake: got valid %b ready %b, expected 0 1", rsp_valid_o, req_ready_o);
    end
    w = exp_wr.pop_front();
    o = (wr_obs.size() == 1) ? wr_obs.pop_front() : '0;
    checks++;
    if (o !== w) begin
      errors++; $display("FAIL stall_wr: got %h %h %h, expected %h %h %h", o.addr, o.data, o.be, w.addr, w.data, w.be);
    end
    wr_obs.delete();
    gnt_delay = 0; rv_delay = 0;
  endtask

  task automatic test_reset_mid();
    int cyc, n, r0;
    rsp_t e; wr_t w, o;
    mem[32'h50] = 32'h0000_1234;
    rv_delay = 6;
    send_req(ArithmeticData, ARITH_ADD, 32'h50, 32'h1, 4'hF);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    r0 = req_cycles;
    checks++;
    if ({req_ready_o, mem_req_o, rsp_valid_o, alu_enable_o} !== 4'b1000 ||
        {mem_addr_o, alu_op1_o, rsp_data_o} !== '0) begin
      errors++; $display("FAIL midrst_state: got rdy %b req %b vld %b addr %h, expected 1 0 0 0",
        req_ready_o, mem_req_o, rsp_valid_o, mem_addr_o);
    end
    n = 0;
    while (rv_pend && n < 50) begin @(negedge clk_i); n++; end
    repeat (3) @(negedge clk_i);
    checks++;
    if (rv_pend || rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || wr_obs.size() != 0 || req_cycles != r0) begin
      errors++; $display("FAIL midrst_stale: got vld %b rdy %b writes %0d reqs %0d, expected 0 1 0 0",
        rsp_valid_o, req_ready_o, wr_obs.size(), req_cycles - r0);
    end
    rv_delay = 0;
    mem[32'h54] = 32'hCAFE_F00D;
    exp_rsp.push_back('{32'hCAFE_F00D, 1'b0});
    exp_wr.push_back('{32'h54, 32'h0BAD_BEEF, 4'hF});
    send_req(LogicalData, LOGIC_SWAP, 32'h54, 32'h0BAD_BEEF, 4'hF);
    wait_rsp(cyc);
    e = exp_rsp.pop_front();
    checks++;
    if (cyc != 5 || {rsp_data_o, rsp_error_o} !== {e.data, e.err}) begin
      errors++; $display("FAIL swap_rsp: got cyc %0d %h/%b, expected cyc 5 %h/%b", cyc, rsp_data_o, rsp_error_o, e.data, e.err);
    end
    @(negedge clk_i);
    w = exp_wr.pop_front();
    o = (wr_obs.size() == 1) ? wr_obs.pop_front() : '0;
    checks++;
    if (o !== w) begin
      errors++; $display("FAIL swap_wr: got %h %h %h, expected %h %h %h", o.addr, o.data, o.be, w.addr, w.data, w.be);
    end
    wr_obs.delete();
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops[3] = '{ArithmeticData, LogicalData, ArithmeticData};
    logic [2:0]  prm[3] = '{ARITH_MAXU, LOGIC_XOR, ARITH_MIN};
    logic [31:0] adr[3] = '{32'h60, 32'h64, 32'h68};
    logic [31:0] old[3] = '{32'h0000_0100, 32'h1122_3344, 32'h0000_0005};
    logic [31:0] opd[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    logic [3:0]  msk[3] = '{4'hF, 4'hC, 4'hF};
    logic [31:0] res[3] = '{32'h8000_0000, 32'hEEDD_3344, 32'hFFFF_FFFE};
    int cyc;
    rsp_t e; wr_t w, o;
    for (int i = 0; i < 3; i++) begin
      mem[adr[i]] = old[i];
      exp_rsp.push_back('{old[i], 1'b0});
      exp_wr.push_back('{adr[i], res[i], msk[i]});
    end
    for (int i = 0; i < 3; i++) begin
      send_req(ops[i], prm[i], adr[i], opd[i], msk[i]);
      wait_rsp(cyc);
      e = exp_rsp.pop_front();
      checks++;
      if (cyc != 5 || {rsp_data_o, rsp_error_o} !== {e.data, e.err}) begin
        errors++; $display("FAIL b2b_rsp[%0d]: got cyc %0d %h/%b, expected cyc 5 %h/%b",
          i, cyc, rsp_data_o, rsp_error_o, e.data, e.err);
      end
      @(negedge clk_i);
      checks++;
      if (req_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b, expected 1", i, req_ready_o); end
      w = exp_wr.pop_front();
      o = (wr_obs.size() == 1) ? wr_obs.pop_front() : '0;
      checks++;
      if (o !== w) begin
        errors++; $display("FAIL b2b_wr[%0d]: got %h %h %h, expected %h %h %h", i, o.addr, o.data, o.be, w.addr, w.data, w.be);
      end
      wr_obs.delete();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_and_partial();
    test_illegal();
    test_read_error();
    test_stalls();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
